// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU funct codes, instruction field
// positions and the decoded bundle handed to the ALU.
package decode_pkg;

  localparam int OPC_W   = 6;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int RIDX_W  = 5;
  localparam int XLEN    = 32;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'd1;
  localparam logic [OPC_W-1:0] OP_SUBI  = 6'd2;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'd3;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'd4;
  localparam logic [OPC_W-1:0] OP_SLLI  = 6'd5;
  localparam logic [OPC_W-1:0] OP_SRLI  = 6'd6;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'd0;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'd1;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'd2;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'd3;
  localparam logic [FUNCT_W-1:0] FN_XOR = 6'd4;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'd5;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'd6;
  localparam logic [FUNCT_W-1:0] FN_SLL = 6'd7;
  localparam logic [FUNCT_W-1:0] FN_SRL = 6'd8;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [IMM_W-1:0]   imm;
    logic [FUNCT_W-1:0] funct;
    logic [RIDX_W-1:0]  dest;
    logic               dest_we;
  } bundle_t;

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    return op <= OP_SRLI;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Two-read, one-write register file with hardwired zero register and
// write-through bypass so a same-cycle writeback is visible to readers.
module regfile_2r1w #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      mem[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    if (ra0 != '0) rd0 = (wb_en && wb_addr == ra0) ? wb_data : mem[ra0];
    if (ra1 != '0) rd1 = (wb_en && wb_addr == ra1) ? wb_data : mem[ra1];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: splits instructions, reads operands, tracks
// in-flight destinations in a busy scoreboard and feeds a one-entry ALU slot.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int DW     = 32,
  parameter int SCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              wb_en,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [DW-1:0]     wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [DW-1:0]     a,
  output logic [DW-1:0]     b,
  output logic [15:0]       imm,
  output logic [5:0]        funct,
  output logic [$clog2(NREG)-1:0] dest,
  output logic              dest_we,
  output logic              illegal_op,
  output logic [SCNT_W-1:0] stall_cnt
);

  localparam int AW = $clog2(NREG);

  function automatic logic [SCNT_W-1:0] sat_inc(input logic [SCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [OPC_W-1:0] op_p0;
  logic [AW-1:0]    rs_p0, rt_p0, rd_p0;
  logic             legal_p0, uses_rt_p0;
  logic [DW-1:0]    rs_val_p0, rt_val_p0;
  logic             rs_wait_p0, rt_wait_p0, hazard_p0, accept_p0;
  bundle_t          bnd_p0;
  logic [NREG-1:0]  busy_q, busy_d;

  bundle_t          bundle_p1;
  logic             vld_p1, ill_p1;
  logic [SCNT_W-1:0] scnt_p1;

  // Stage p0: field split, operand read, hazard check
  assign op_p0      = instr[OPC_HI:OPC_LO];
  assign rs_p0      = instr[RS_HI:RS_LO];
  assign rt_p0      = instr[RT_HI:RT_LO];
  assign rd_p0      = instr[RD_HI:RD_LO];
  assign legal_p0   = op_legal(op_p0);
  assign uses_rt_p0 = (op_p0 == OP_RTYPE);

  regfile_2r1w #(.NREG(NREG), .DW(DW), .AW(AW)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .ra0     (rs_p0),
    .ra1     (rt_p0),
    .rd0     (rs_val_p0),
    .rd1     (rt_val_p0)
  );

  // A writeback landing this cycle resolves the dependency through the bypass.
  assign rs_wait_p0 = (rs_p0 != '0) && busy_q[rs_p0] && !(wb_en && wb_addr == rs_p0);
  assign rt_wait_p0 = uses_rt_p0 && (rt_p0 != '0) && busy_q[rt_p0]
                      && !(wb_en && wb_addr == rt_p0);
  // Kept independent of in_valid so in_ready never combinationally follows it.
  assign hazard_p0  = legal_p0 && (rs_wait_p0 || rt_wait_p0);

  assign in_ready  = !rst && (!vld_p1 || out_ready) && !hazard_p0;
  assign accept_p0 = in_valid && in_ready;

  always_comb begin
    bnd_p0.opcode  = op_p0;
    bnd_p0.a       = rs_val_p0;
    bnd_p0.b       = uses_rt_p0 ? rt_val_p0 : '0;
    bnd_p0.imm     = instr[IMM_HI:IMM_LO];
    bnd_p0.funct   = instr[FUNCT_HI:FUNCT_LO];
    bnd_p0.dest    = uses_rt_p0 ? rd_p0 : rt_p0;
    bnd_p0.dest_we = legal_p0 && (bnd_p0.dest != '0);
  end

  // Set after clear so a new claim on a register wins over its retiring write.
  always_comb begin
    busy_d = busy_q;
    if (wb_en && wb_addr != '0) busy_d[wb_addr] = 1'b0;
    if (accept_p0 && bnd_p0.dest_we) busy_d[bnd_p0.dest] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Stage p1: registered ALU slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      ill_p1    <= 1'b0;
      scnt_p1   <= '0;
      bundle_p1 <= '0;
    end else begin
      ill_p1 <= accept_p0 && !legal_p0;
      if (in_valid && hazard_p0) scnt_p1 <= sat_inc(scnt_p1);
      if (accept_p0 && legal_p0) begin
        vld_p1    <= 1'b1;
        bundle_p1 <= bnd_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign opcode     = bundle_p1.opcode;
  assign a          = bundle_p1.a;
  assign b          = bundle_p1.b;
  assign imm        = bundle_p1.imm;
  assign funct      = bundle_p1.funct;
  assign dest       = bundle_p1.dest;
  assign dest_we    = bundle_p1.dest_we;
  assign illegal_op = ill_p1;
  assign stall_cnt  = scnt_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a behavioural model
// of the register file, scoreboard and output slot.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, wb_en, out_valid, out_ready;
  logic        dest_we, illegal_op;
  logic [31:0] instr, wb_data, a, b;
  logic [4:0]  wb_addr, dest;
  logic [5:0]  opcode, funct;
  logic [15:0] imm, stall_cnt;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .a(a),
    .b(b), .imm(imm), .funct(funct), .dest(dest), .dest_we(dest_we),
    .illegal_op(illegal_op), .stall_cnt(stall_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference state
  logic [31:0] m_rf [32];
  logic [31:0] m_busy;
  logic        m_vld, m_ill, m_we;
  logic [15:0] m_scnt, m_imm;
  logic [5:0]  m_op, m_funct;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_dest;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    logic [31:0] w;
    w = 32'd0;
    w[25:21] = 5'(rs); w[20:16] = 5'(rt); w[15:11] = 5'(rd); w[5:0] = 6'(fn);
    return w;
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int im);
    logic [31:0] w;
    w[31:26] = 6'(op); w[25:21] = 5'(rs); w[20:16] = 5'(rt); w[15:0] = 16'(im);
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_busy = '0; m_vld = 0; m_ill = 0; m_we = 0; m_scnt = '0; m_imm = '0;
    m_op = '0; m_funct = '0; m_a = '0; m_b = '0; m_dest = '0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".out_valid"}, out_valid, m_vld);
    chk({ctx, ".illegal_op"}, illegal_op, m_ill);
    chk({ctx, ".stall_cnt"}, stall_cnt, m_scnt);
    chk({ctx, ".busy"}, dut.busy_q, m_busy);
    if (m_vld) begin
      chk({ctx, ".opcode"}, opcode, m_op);
      chk({ctx, ".a"}, a, m_a);
      chk({ctx, ".b"}, b, m_b);
      chk({ctx, ".imm"}, imm, m_imm);
      chk({ctx, ".funct"}, funct, m_funct);
      chk({ctx, ".dest"}, dest, m_dest);
      chk({ctx, ".dest_we"}, dest_we, m_we);
    end
  endtask

  // One clock cycle: drive at negedge, check in_ready, advance the model, check outputs.
  task automatic step(input logic iv, input logic [31:0] ins, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
    logic [5:0] op;
    logic [4:0] rs, rt, rd, dst;
    logic       legal, rt_src, haz, exp_rdy, acc;
    logic [31:0] va, vb;
    in_valid = iv; instr = ins; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #1;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    legal  = (op < 6'd7);
    rt_src = (op == 6'd0);
    haz = 0;
    if (legal && rs != 0 && m_busy[rs] && !(we && wa == rs)) haz = 1;
    if (legal && rt_src && rt != 0 && m_busy[rt] && !(we && wa == rt)) haz = 1;
    exp_rdy = (!m_vld || ordy) && !haz;
    chk("in_ready", in_ready, exp_rdy);
    acc = iv && exp_rdy;
    va = (rs == 0) ? 32'd0 : (we && wa == rs) ? wd : m_rf[rs];
    vb = (rt == 0) ? 32'd0 : (we && wa == rt) ? wd : m_rf[rt];
    dst = rt_src ? rd : rt;
    if (acc && legal) begin
      m_vld = 1; m_op = op; m_a = va; m_b = rt_src ? vb : 32'd0;
      m_imm = ins[15:0]; m_funct = ins[5:0]; m_dest = dst; m_we = (dst != 0);
    end else if (ordy) begin
      m_vld = 0;
    end
    m_ill = acc && !legal;
    if (iv && haz && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
    if (we && wa != 0) begin m_busy[wa] = 1'b0; m_rf[wa] = wd; end
    if (acc && legal && dst != 0) m_busy[dst] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  // Asynchronous reset raised between clock edges.
  task automatic hard_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    chk("rst.in_ready", in_ready, 1'b0);
    chk("rst.a", a, 32'd0);
    chk("rst.dest", dest, 5'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] ins;
    rst = 0; in_valid = 0; instr = '0; wb_en = 0; wb_addr = '0; wb_data = '0; out_ready = 1;
    @(negedge clk);
    hard_reset();

    // Writeback then R-type add
    step(0, 32'd0, 1, 5'd1, 32'd5, 1);
    step(0, 32'd0, 1, 5'd2, 32'd7, 1);
    step(1, rtype(1, 2, 3, FN_ADD), 0, 5'd0, 32'd0, 1);
    chk("add.out_valid", out_valid, 1'b1);
    chk("add.a", a, 32'd5);
    chk("add.b", b, 32'd7);
    chk("add.dest", dest, 5'd3);
    chk("add.dest_we", dest_we, 1'b1);
    chk("add.busy3", dut.busy_q[3], 1'b1);

    // RAW stall on r3 resolved through writeback bypass
    for (int i = 0; i < 3; i++) step(1, itype(OP_ADDI, 3, 4, 1), 0, 5'd0, 32'd0, 1);
    chk("stall.cnt", stall_cnt, 16'd3);
    step(1, itype(OP_ADDI, 3, 4, 1), 1, 5'd3, 32'd12, 1);
    chk("bypass.a", a, 32'd12);
    chk("bypass.imm", imm, 16'd1);
    chk("bypass.b", b, 32'd0);

    // Backpressure: bundle held for three cycles
    step(1, itype(OP_ADDI, 1, 5, 2), 0, 5'd0, 32'd0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, itype(OP_ORI, 2, 6, 3), 0, 5'd0, 32'd0, 0);
      chk("hold.a", a, 32'd5);
    end
    step(1, itype(OP_ORI, 2, 6, 3), 0, 5'd0, 32'd0, 1);
    chk("release.a", a, 32'd7);

    // Illegal opcode
    step(1, itype(7, 1, 8, 0), 0, 5'd0, 32'd0, 1);
    chk("ill.pulse", illegal_op, 1'b1);
    chk("ill.out_valid", out_valid, 1'b0);
    step(0, 32'd0, 0, 5'd0, 32'd0, 1);
    chk("ill.drop", illegal_op, 1'b0);

    // rd=0 and zero register
    step(1, rtype(1, 2, 0, FN_SUB), 0, 5'd0, 32'd0, 1);
    chk("rd0.dest_we", dest_we, 1'b0);
    step(0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF, 1);
    step(1, rtype(0, 0, 7, FN_OR), 0, 5'd0, 32'd0, 1);
    chk("r0.a", a, 32'd0);
    chk("r0.b", b, 32'd0);

    // Reset during a stall with a held bundle
    step(1, rtype(1, 2, 3, FN_ADD), 0, 5'd0, 32'd0, 1);
    step(1, itype(OP_ADDI, 3, 4, 1), 0, 5'd0, 32'd0, 0);
    hard_reset();
    chk("rstmid.busy", dut.busy_q, 32'd0);
    chk("rstmid.stall", stall_cnt, 16'd0);
    step(1, itype(OP_ADDI, 3, 4, 1), 0, 5'd0, 32'd0, 1);
    chk("rstmid.accept", out_valid, 1'b1);
    chk("rstmid.a", a, 32'd0);

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      int r;
      ins = $urandom;
      r = $urandom_range(0, 15);
      if (r < 6)       ins[31:26] = 6'd0;
      else if (r < 14) ins[31:26] = 6'($urandom_range(1, 6));
      else             ins[31:26] = 6'($urandom_range(7, 63));
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) < 4,
           5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0);
      if (i == 1500) hard_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
